// File: rtl/sram_read_unpacker_if.sv
// Handshake bundle between the SRAM read port side and the narrow user read side.
// in_sext is present only when OUT_SHIFTER_SEXT_EN is defined.
interface sram_read_unpacker_if #(
    parameter int WORD_W = 32,
    parameter int MIN_W  = 8
);
    localparam int MAX_LANES = WORD_W / MIN_W;
    localparam int SEL_W     = ($clog2(MAX_LANES) < 1) ? 1 : $clog2(MAX_LANES);
    localparam int CONF_W    = ($clog2($clog2(MAX_LANES) + 1) < 1) ? 1 : $clog2($clog2(MAX_LANES) + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [CONF_W-1:0] in_conf;
    logic [SEL_W-1:0]  in_addr;
    logic              in_burst;
`ifdef OUT_SHIFTER_SEXT_EN
    logic              in_sext;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [SEL_W-1:0]  out_lane;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_conf, in_addr, in_burst,
`ifdef OUT_SHIFTER_SEXT_EN
        output in_sext,
`endif
        input  in_ready,
        input  out_valid, out_data, out_lane, out_last,
        output out_ready
    );

    modport slave (
        input  in_valid, in_data, in_conf, in_addr, in_burst,
`ifdef OUT_SHIFTER_SEXT_EN
        input  in_sext,
`endif
        output in_ready,
        output out_valid, out_data, out_lane, out_last,
        input  out_ready
    );
endinterface

// File: rtl/sram_read_unpacker.sv
// Registered lane unpacker: emits one lane (single) or all lanes wrapping from the start lane (burst).
// Optional sign extension of narrow lanes is enabled by defining OUT_SHIFTER_SEXT_EN.
module sram_read_unpacker #(
    parameter int WORD_W = 32,
    parameter int MIN_W  = 8
) (
    input logic clk,
    input logic rst,
    sram_read_unpacker_if.slave bus
);
    localparam int MAX_LANES = WORD_W / MIN_W;
    localparam int LOG_LANES = $clog2(MAX_LANES);
    localparam int SEL_W     = (LOG_LANES < 1) ? 1 : LOG_LANES;
    localparam int CONF_W    = ($clog2(LOG_LANES + 1) < 1) ? 1 : $clog2(LOG_LANES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] word_reg;
    logic [CONF_W-1:0] k_reg;
    logic [SEL_W-1:0]  remaining_reg;
    logic              out_valid_reg;
    logic [WORD_W-1:0] out_data_reg;
    logic [SEL_W-1:0]  out_lane_reg;
    logic              out_last_reg;
`ifdef OUT_SHIFTER_SEXT_EN
    logic              sext_reg;
    logic              sel_sext;
`endif

    logic              accept;
    logic [CONF_W-1:0] conf_clamped;
    logic [WORD_W-1:0] sel_word;
    logic [CONF_W-1:0] sel_k;
    logic [SEL_W-1:0]  sel_idx;
    logic [WORD_W-1:0] lane_val [0:LOG_LANES];
    logic [SEL_W-1:0]  idx_by_k [0:LOG_LANES];
    logic [WORD_W-1:0] data_next;
    logic [SEL_W-1:0]  lane_next;

    assign bus.in_ready  = (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_lane  = out_lane_reg;
    assign bus.out_last  = out_last_reg;

    assign accept       = bus.in_valid && bus.in_ready;
    assign conf_clamped = (bus.in_conf > CONF_W'(LOG_LANES)) ? CONF_W'(LOG_LANES) : bus.in_conf;

    // One extractor serves both paths: the live input on accept, the latched word while bursting.
    assign sel_word = (state_reg == IDLE) ? bus.in_data  : word_reg;
    assign sel_k    = (state_reg == IDLE) ? conf_clamped : k_reg;
    assign sel_idx  = (state_reg == IDLE) ? bus.in_addr  : out_lane_reg + SEL_W'(1);
`ifdef OUT_SHIFTER_SEXT_EN
    assign sel_sext = (state_reg == IDLE) ? bus.in_sext  : sext_reg;
`endif

    generate
        for (genvar gi = 0; gi <= LOG_LANES; gi++) begin : g_lane
            localparam int LW = WORD_W >> gi;
            localparam logic [WORD_W-1:0] LANE_MASK = {WORD_W{1'b1}} >> (WORD_W - LW);
            logic [WORD_W-1:0] shifted;

            assign idx_by_k[gi] = sel_idx & SEL_W'((1 << gi) - 1);
            assign shifted      = sel_word >> (int'(idx_by_k[gi]) * LW);
`ifdef OUT_SHIFTER_SEXT_EN
            assign lane_val[gi] = (shifted & LANE_MASK)
                                | ((sel_sext && (LW < WORD_W)) ? ({WORD_W{shifted[LW-1]}} & ~LANE_MASK)
                                                                : '0);
`else
            assign lane_val[gi] = shifted & LANE_MASK;
`endif
        end
    endgenerate

    always_comb begin
        data_next = '0;
        lane_next = '0;
        for (int i = 0; i <= LOG_LANES; i++) begin
            if (sel_k == CONF_W'(i)) begin
                data_next = lane_val[i];
                lane_next = idx_by_k[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            k_reg         <= '0;
            remaining_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_lane_reg  <= '0;
            out_last_reg  <= 1'b0;
`ifdef OUT_SHIFTER_SEXT_EN
            sext_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        word_reg      <= bus.in_data;
                        k_reg         <= conf_clamped;
`ifdef OUT_SHIFTER_SEXT_EN
                        sext_reg      <= bus.in_sext;
`endif
                        out_data_reg  <= data_next;
                        out_lane_reg  <= lane_next;
                        out_valid_reg <= 1'b1;
                        if (bus.in_burst && conf_clamped != '0) begin
                            remaining_reg <= SEL_W'((1 << conf_clamped) - 1);
                            out_last_reg  <= 1'b0;
                            state_reg     <= BUSY;
                        end else begin
                            out_last_reg  <= 1'b1;
                        end
                    end else if (out_valid_reg && bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.out_ready) begin
                        out_data_reg  <= data_next;
                        out_lane_reg  <= lane_next;
                        remaining_reg <= remaining_reg - SEL_W'(1);
                        if (remaining_reg == SEL_W'(1)) begin
                            out_last_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_read_unpacker.sv
// Directed bench for sram_read_unpacker with hand-computed expected beats.
module tb_sram_read_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_read_unpacker_if #(.WORD_W(32), .MIN_W(8)) bus ();

    sram_read_unpacker #(.WORD_W(32), .MIN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] WORD = 32'hDDCCBBAA;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] conf, input logic [1:0] addr, input logic burst);
        bus.in_valid = v;
        bus.in_data  = WORD;
        bus.in_conf  = conf;
        bus.in_addr  = addr;
        bus.in_burst = burst;
    endtask

    task automatic check_beat(input string name, input logic [31:0] data, input logic [1:0] lane, input logic last);
        total++;
        $display("beat %s: valid=%0b data=%08h lane=%0d last=%0b ready=%0b", name,
                 bus.out_valid, bus.out_data, bus.out_lane, bus.out_last, bus.in_ready);
        if (bus.out_valid !== 1'b1 || bus.out_data !== data || bus.out_lane !== lane || bus.out_last !== last) begin
            bad++;
            $display("FAIL %s: got valid=%0b data=%08h lane=%0d last=%0b, want valid=1 data=%08h lane=%0d last=%0b",
                     name, bus.out_valid, bus.out_data, bus.out_lane, bus.out_last, data, lane, last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        bus.out_ready = 1'b1;
`ifdef OUT_SHIFTER_SEXT_EN
        bus.in_sext = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_lane !== 2'd0 ||
            bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: got valid=%0b data=%08h lane=%0d last=%0b ready=%0b, want 0 0 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_lane, bus.out_last, bus.in_ready);
        end
        $display("reset: valid=%0b ready=%0b", bus.out_valid, bus.in_ready);
    endtask

    task automatic test_single_k0();
        drive(1'b1, 2'd0, 2'd3, 1'b0);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        check_beat("single_k0", 32'hDDCCBBAA, 2'd0, 1'b1);
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got out_valid=%0b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd2, 2'd2, 1'b0);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready0: got in_ready=%0b, want 1", bus.in_ready);
        end
        tick();
        drive(1'b1, 2'd1, 2'd1, 1'b0);
        check_beat("b2b_k2", 32'h000000CC, 2'd2, 1'b1);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready1: got in_ready=%0b, want 1", bus.in_ready);
        end
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        check_beat("b2b_k1", 32'h0000DDCC, 2'd1, 1'b1);
        tick();
    endtask

    task automatic test_burst();
        logic [31:0] exp_data [4] = '{32'hDD, 32'hAA, 32'hBB, 32'hCC};
        logic [1:0]  exp_lane [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
        int busy_cycles = 0;
        drive(1'b1, 2'd2, 2'd3, 1'b1);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("burst_%0d", i), exp_data[i], exp_lane[i], (i == 3));
            if (bus.in_ready === 1'b0) busy_cycles++;
            tick();
        end
        total++;
        if (busy_cycles != 3 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_ready: got busy=%0d valid_after=%0b, want busy=3 valid_after=0",
                     busy_cycles, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd2, 2'd3, 1'b1);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        check_beat("bp_0", 32'hDD, 2'd3, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("bp_hold_%0d", i), 32'hAA, 2'd0, 1'b0);
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready_%0d: got in_ready=%0b, want 0", i, bus.in_ready);
            end
            if (i < 2) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_beat("bp_2", 32'hBB, 2'd1, 1'b0);
        tick();
        check_beat("bp_3", 32'hCC, 2'd2, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 2'd2, 2'd3, 1'b1);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        check_beat("rmb_beat2", 32'hAA, 2'd0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 2'd0, 2'd0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmb_reset: got valid=%0b data=%08h ready=%0b, want 0 00000000 1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmb_quiet: got out_valid=%0b, want 0", bus.out_valid);
        end
        drive(1'b1, 2'd0, 2'd2, 1'b0);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        check_beat("rmb_after", 32'hDDCCBBAA, 2'd0, 1'b1);
        tick();
    endtask

    task automatic test_clamp();
        drive(1'b1, 2'd3, 2'd1, 1'b0);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
        check_beat("clamp_k3", 32'h000000BB, 2'd1, 1'b1);
        tick();
    endtask

    task automatic test_sext();
`ifdef OUT_SHIFTER_SEXT_EN
        bus.in_sext = 1'b1;
`endif
        drive(1'b1, 2'd2, 2'd3, 1'b0);
        tick();
        drive(1'b0, 2'd0, 2'd0, 1'b0);
`ifdef OUT_SHIFTER_SEXT_EN
        bus.in_sext = 1'b0;
        check_beat("sext_k2", 32'hFFFFFFDD, 2'd3, 1'b1);
`else
        check_beat("sext_k2", 32'h000000DD, 2'd3, 1'b1);
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_single_k0();
        test_back_to_back();
        test_burst();
        test_backpressure();
        test_reset_mid_burst();
        test_clamp();
        test_sext();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
